// File: rtl/adder_tree_sched_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | adder_tree_sched_if: requester, tree and response signals of the       |
// | adder-tree scheduler. Rev 1.0                                          |
// +------------------------------------------------------------------------+
interface adder_tree_sched_if #(
  parameter int NUM_REQ    = 4,
  parameter int INWIDTH    = 16,
  parameter int NUM_INPUTS = 45,
  parameter int OUTWIDTH   = 23,
  parameter int ID_W       = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]                    req_valid;
  logic [NUM_REQ*NUM_INPUTS*INWIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                    req_ready;
  logic [NUM_INPUTS*INWIDTH-1:0]         tree_din;
  logic                                  tree_din_valid;
  logic                                  tree_en;
  logic [OUTWIDTH-1:0]                   tree_dout;
  logic                                  tree_dout_valid;
  logic                                  rsp_valid;
  logic [ID_W-1:0]                       rsp_id;
  logic [OUTWIDTH-1:0]                   rsp_data;
  logic                                  rsp_ready;

  // Environment side: requesters, adder tree and result consumer.
  modport master (
    output req_valid, req_data, tree_dout, tree_dout_valid, rsp_ready,
    input  req_ready, tree_din, tree_din_valid, tree_en, rsp_valid, rsp_id, rsp_data
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_data, tree_dout, tree_dout_valid, rsp_ready,
    output req_ready, tree_din, tree_din_valid, tree_en, rsp_valid, rsp_id, rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/adder_tree_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | adder_tree_sched: round-robin, credit-controlled sharing of one adder  |
// | tree. Optional counters: define ADDER_TREE_SCHED_STATS_EN. Rev 1.0     |
// +------------------------------------------------------------------------+
module adder_tree_sched #(
  parameter int NUM_REQ    = 4,
  parameter int INWIDTH    = 16,
  parameter int NUM_INPUTS = 45,
  parameter int LATENCY    = 7,
  parameter int OUTWIDTH   = 23,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  flush,
  adder_tree_sched_if.slave     bus,
  output logic                  busy,
  output logic                  err_tag
`ifdef ADDER_TREE_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_issue,
  output logic [31:0]           stat_stall
`endif
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int DW    = NUM_INPUTS * INWIDTH;
  localparam int EW    = ID_W + OUTWIDTH;
  localparam logic [CNT_W:0]  C_DEPTH = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ID_W-1:0] C_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [ID_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [LATENCY-1:0]          tag_valid_q, tag_valid_d;
  logic [LATENCY-1:0][ID_W-1:0] tag_id_q, tag_id_d;
  logic [CNT_W-1:0]            inflight_q, inflight_d;
  logic [CNT_W-1:0]            fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH-1:0][EW-1:0] mem_q, mem_d;
  logic [EW-1:0]               head_q, head_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic                        err_tag_q, err_tag_d;

  logic [NUM_REQ-1:0]          grant;
  logic [ID_W-1:0]             grant_id;
  logic                        grant_any;
  logic                        credit_ok;
  logic                        any_req;
  logic                        tag_exit;
  logic                        pop;
  logic [DW-1:0]               din_mux;
  int                          arb_idx;

  assign any_req   = |bus.req_valid;
  // Registered counts only: a pop this cycle frees credit from the next cycle on.
  assign credit_ok = ({1'b0, fifo_count_q} + {1'b0, inflight_q}) < C_DEPTH;
  assign tag_exit  = en & tag_valid_q[LATENCY-1];
  assign pop       = rsp_valid_q & bus.rsp_ready;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    arb_idx   = 0;
    if (state_q == S_ISSUE && en && !flush && credit_ok) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        arb_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
        if (!grant_any && bus.req_valid[arb_idx]) begin
          grant_any        = 1'b1;
          grant[arb_idx]   = 1'b1;
          grant_id         = ID_W'(arb_idx);
        end
      end
    end
  end

  always_comb begin
    din_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) din_mux = bus.req_data[i*DW +: DW];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) rr_ptr_d = (grant_id == C_LAST) ? '0 : grant_id + ID_W'(1);
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        S_IDLE:  if (any_req && !flush) state_d = S_ISSUE;
        S_ISSUE: begin
          if (flush)                              state_d = S_DRAIN;
          else if (!any_req && inflight_q == '0)  state_d = S_IDLE;
        end
        S_DRAIN: if (inflight_q == '0 && fifo_count_q == '0 && !flush) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Tag pipeline mirrors the tree: it advances exactly when the tree does.
  always_comb begin
    tag_valid_d = tag_valid_q;
    tag_id_d    = tag_id_q;
    err_tag_d   = err_tag_q;
    if (en) begin
      tag_valid_d[0] = grant_any;
      tag_id_d[0]    = grant_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid_d[i] = tag_valid_q[i-1];
        tag_id_d[i]    = tag_id_q[i-1];
      end
      if (tag_valid_q[LATENCY-1] != bus.tree_dout_valid) err_tag_d = 1'b1;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({grant_any, tag_exit})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (tag_exit) begin
      mem_d[wr_ptr_q] = {tag_id_q[LATENCY-1], bus.tree_dout};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({tag_exit, pop})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
    rsp_valid_d = (fifo_count_d != '0);
    head_d      = mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      tag_valid_q  <= '0;
      tag_id_q     <= '0;
      inflight_q   <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      head_q       <= '0;
      rsp_valid_q  <= 1'b0;
      err_tag_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      tag_valid_q  <= tag_valid_d;
      tag_id_q     <= tag_id_d;
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      head_q       <= head_d;
      rsp_valid_q  <= rsp_valid_d;
      err_tag_q    <= err_tag_d;
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef ADDER_TREE_SCHED_STATS_EN
  logic [31:0] stat_issue_q, stat_issue_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_issue_d = stat_issue_q;
    stat_stall_d = stat_stall_q;
    if (grant_any && stat_issue_q != '1) stat_issue_d = stat_issue_q + 32'd1;
    if (en && any_req && !credit_ok && stat_stall_q != '1) stat_stall_d = stat_stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issue_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_issue_q <= stat_issue_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_issue = stat_issue_q;
  assign stat_stall = stat_stall_q;
`endif

  assign bus.req_ready      = grant;
  assign bus.tree_din       = din_mux;
  assign bus.tree_din_valid = grant_any;
  assign bus.tree_en        = en;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_id         = head_q[OUTWIDTH +: ID_W];
  assign bus.rsp_data       = head_q[OUTWIDTH-1:0];
  assign busy               = (inflight_q != '0) || (fifo_count_q != '0) || (state_q != S_IDLE);
  assign err_tag            = err_tag_q;
endmodule
`default_nettype wire

// File: tb/tb_adder_tree_sched.sv
`default_nettype none
// Bench for adder_tree_sched: directed vectors, 7-stage tree model that freezes
// with tree_en, and a scoreboard queue popped by an independent response monitor.
module tb_adder_tree_sched;
  localparam int NREQ = 4;
  localparam int INW  = 16;
  localparam int NIN  = 45;
  localparam int LAT  = 7;
  localparam int OUTW = 23;

  typedef struct packed {
    logic [1:0]      id;
    logic [OUTW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset, en, flush, inj;
  logic busy, err_tag;
`ifdef ADDER_TREE_SCHED_STATS_EN
  logic [31:0] stat_issue, stat_stall;
`endif

  adder_tree_sched_if #(.NUM_REQ(NREQ), .INWIDTH(INW), .NUM_INPUTS(NIN), .OUTWIDTH(OUTW)) bus ();

  adder_tree_sched #(
    .NUM_REQ(NREQ), .INWIDTH(INW), .NUM_INPUTS(NIN), .LATENCY(LAT),
    .OUTWIDTH(OUTW), .FIFO_DEPTH(8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .flush   (flush),
    .bus     (bus.slave),
    .busy    (busy),
    .err_tag (err_tag)
`ifdef ADDER_TREE_SCHED_STATS_EN
    ,
    .stat_issue (stat_issue),
    .stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rsp = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [15:0] vals [NREQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh2id(input logic [NREQ-1:0] oh);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < NREQ; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  // Tree model: sum of 45 inputs, 7 stages, advancing only with tree_en.
  logic [LAT-1:0]           tv_q;
  logic [LAT-1:0][OUTW-1:0] ts_q;
  logic [OUTW-1:0]          din_sum;
  always_comb begin
    din_sum = '0;
    for (int i = 0; i < NIN; i++) din_sum = din_sum + OUTW'(bus.tree_din[i*INW +: INW]);
  end
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tv_q <= '0;
      ts_q <= '0;
    end else if (bus.tree_en) begin
      tv_q <= {tv_q[LAT-2:0], bus.tree_din_valid};
      ts_q <= {ts_q[LAT-2:0], din_sum};
    end
  end
  assign bus.tree_dout       = ts_q[LAT-1];
  assign bus.tree_dout_valid = tv_q[LAT-1] | inj;

  // Scoreboard: push at issue, pop and compare on every accepted response.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_id", 32'(bus.rsp_id), 32'(mon_e.id));
          chk("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
          n_rsp++;
        end
      end
      if (bus.tree_din_valid)
        sb.push_back({oh2id(bus.req_ready), OUTW'(45 * vals[oh2id(bus.req_ready)])});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load();
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < NIN; j++)
        bus.req_data[(i*NIN + j)*INW +: INW] = vals[i];
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while ((sb.size() != 0 || busy) && c < 300) begin
      step();
      c++;
    end
    chk(name, 32'(c < 300), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int ng, gr, nb, cnt, lat, enh, base, stalls;
    logic started, found;
    logic [1:0] got [16];
`ifdef ADDER_TREE_SCHED_STATS_EN
    logic [31:0] ss0;
`endif
    reset = 1'b1; en = 1'b0; flush = 1'b0; inj = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) vals[i] = 16'h0000;
    load();

    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_din_valid", 32'(bus.tree_din_valid), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_tag", 32'(err_tag), 32'd0);
`ifdef ADDER_TREE_SCHED_STATS_EN
    chk("rst_stat_issue", stat_issue, 32'd0);
`endif
    step(); step();
    reset = 1'b0; en = 1'b1;
    step();

    // Single op from requester 2, all inputs 1 -> 45 after LATENCY+1 cycles.
    base = n_rsp;
    vals[2] = 16'h0001;
    load();
    bus.req_valid = 4'b0100;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (bus.req_ready[2]) found = 1'b1;
      chk("tree_en_eq_en", 32'(bus.tree_en), 32'(en));
      step();
    end
    chk("single_grant_seen", 32'(found), 32'd1);
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_pulse", 32'(bus.req_ready), 32'd0);
    chk("din_zero_idle", 32'(bus.tree_din[31:0]), 32'd0);
    cnt = 1;
    while (!bus.rsp_valid && cnt < 20) begin
      step();
      @(negedge clk);
      cnt++;
    end
    chk("single_latency", 32'(cnt), 32'd8);
    chk("single_id", 32'(bus.rsp_id), 32'd2);
    chk("single_data", 32'(bus.rsp_data), 32'd45);
    step();
    wait_idle("single_drain");
    chk("single_count", 32'(n_rsp - base), 32'd1);

    // All four valid: round robin continues from pointer 3 after the grant to 2.
    base = n_rsp;
    vals[0] = 16'h0010; vals[1] = 16'h0123; vals[2] = 16'h8000; vals[3] = 16'hFFFF;
    load();
    bus.req_valid = 4'b1111;
    ng = 0;
    for (int c = 0; c < 300 && ng < 16; c++) begin
      @(negedge clk);
      if (|bus.req_ready) begin
        got[ng] = oh2id(bus.req_ready);
        ng++;
      end
      step();
    end
    bus.req_valid = '0;
    chk("rr_grants", 32'(ng), 32'd16);
    for (int i = 0; i < 16; i++) chk("rr_order", 32'(got[i]), 32'((3 + i) % 4));
    wait_idle("rr_drain");
    chk("rr_count", 32'(n_rsp - base), 32'd16);

    // Consumer stalled: credit limits to 8 grants; a pop restores credit next cycle.
    base = n_rsp;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0010;
    ng = 0; stalls = 0;
`ifdef ADDER_TREE_SCHED_STATS_EN
    ss0 = stat_stall;
`endif
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.req_ready[1]) ng++;
      else if (ng == 8) stalls++;
      step();
    end
    chk("credit_grants", 32'(ng), 32'd8);
    chk("credit_full_valid", 32'(bus.rsp_valid), 32'd1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("credit_same_cycle", 32'(bus.req_ready), 32'd0);
    step();
    @(negedge clk);
    chk("credit_resume", 32'(bus.req_ready), 32'b0010);
    step();
    bus.req_valid = '0;
`ifdef ADDER_TREE_SCHED_STATS_EN
    chk("stat_stall", stat_stall - ss0, 32'(stalls + 1));
`endif
    wait_idle("credit_drain");
    chk("credit_count", 32'(n_rsp - base), 32'd9);

    // en toggling: three ops, tags and tree freeze together.
    base = n_rsp;
    bus.req_valid = 4'b0111;
    ng = 0; enh = 0; lat = -1; started = 1'b0;
    for (int c = 0; c < 80; c++) begin
      en = (c % 2 == 0);
      if (ng == 3) bus.req_valid = '0;
      @(negedge clk);
      if (bus.rsp_valid && lat < 0) lat = enh;
      if (en && |bus.req_ready) begin
        ng++;
        started = 1'b1;
      end
      if (started && en) enh++;
      step();
    end
    en = 1'b1;
    bus.req_valid = '0;
    chk("entog_grants", 32'(ng), 32'd3);
    chk("entog_latency", 32'(lat), 32'd8);
    chk("entog_err_tag", 32'(err_tag), 32'd0);
    wait_idle("entog_drain");
    chk("entog_count", 32'(n_rsp - base), 32'd3);

    // Flush with five ops in flight.
    base = n_rsp;
    bus.req_valid = 4'b1111;
    ng = 0;
    for (int c = 0; c < 20 && ng < 5; c++) begin
      @(negedge clk);
      if (|bus.req_ready) ng++;
      step();
    end
    flush = 1'b1;
    gr = 0; nb = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (|bus.req_ready) gr++;
      if (!busy) nb++;
      step();
    end
    chk("flush_issued", 32'(ng), 32'd5);
    chk("flush_no_grant", 32'(gr), 32'd0);
    chk("flush_busy_held", 32'(nb), 32'd0);
    chk("flush_count", 32'(n_rsp - base), 32'd5);
    flush = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    chk("flush_busy_last", 32'(busy), 32'd1);
    step();
    @(negedge clk);
    chk("flush_idle", 32'(busy), 32'd0);
    step();

    // Asynchronous reset mid-burst, then an unmatched tree valid.
    bus.req_valid = 4'b1111;
    ng = 0;
    for (int c = 0; c < 20 && ng < 3; c++) begin
      @(negedge clk);
      if (|bus.req_ready) ng++;
      step();
    end
    reset = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("mid_rst_din_valid", 32'(bus.tree_din_valid), 32'd0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err_tag", 32'(err_tag), 32'd0);
    step();
    reset = 1'b0;
    step();
    inj = 1'b1;
    step();
    inj = 1'b0;
    @(negedge clk);
    chk("inject_err_tag", 32'(err_tag), 32'd1);
    chk("inject_no_rsp", 32'(bus.rsp_valid), 32'd0);
    step(); step(); step();
    @(negedge clk);
    chk("err_tag_sticky", 32'(err_tag), 32'd1);
    chk("inject_not_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
